// File: rtl/lf_pkg.sv
// Shared constants and FSM state type for the LF ADC decimator family.
package lf_pkg;

  localparam int unsigned SAMPLE_W = 8;
  localparam int unsigned MAX_LOG2 = 7;
  localparam int unsigned ACC_W    = SAMPLE_W + MAX_LOG2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_e;

endpackage

// File: rtl/lf_minmax_track.sv
// Running min/max tracker. The first sample of a run loads both extremes directly.
// min_c/max_c show the extremes including the current sample, before it is registered.
module lf_minmax_track
  import lf_pkg::*;
#(
  parameter int unsigned W = SAMPLE_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         first,
  input  logic [W-1:0] sample,
  output logic [W-1:0] min_c,
  output logic [W-1:0] max_c
);

  logic [W-1:0] min_q;
  logic [W-1:0] max_q;

  always_comb begin
    min_c = sample;
    max_c = sample;
    if (!first) begin
      if (min_q < sample) min_c = min_q;
      if (max_q > sample) max_c = max_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      min_q <= '0;
      max_q <= '0;
    end else if (load) begin
      min_q <= min_c;
      max_q <= max_c;
    end
  end

endmodule

// File: rtl/lf_adc_decimator.sv
// LF ADC sample decimator: averages 2^decim_log2 samples per window and reports
// avg/min/max through a one-deep valid/ready buffer with a sticky overrun flag.
module lf_adc_decimator #(
  parameter int unsigned SAMPLE_W = lf_pkg::SAMPLE_W,
  parameter int unsigned MAX_LOG2 = lf_pkg::MAX_LOG2
) (
  input  logic                pck0,
  input  logic                reset,
  input  logic                enable,
  input  logic                adc_clk,
  input  logic [SAMPLE_W-1:0] adc_d,
  input  logic [2:0]          decim_log2,
  input  logic                clr_overrun,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [SAMPLE_W-1:0] out_avg,
  output logic [SAMPLE_W-1:0] out_min,
  output logic [SAMPLE_W-1:0] out_max,
  output logic                overrun
);

  localparam int unsigned ACC_W = SAMPLE_W + MAX_LOG2;
  localparam int unsigned CNT_W = MAX_LOG2 + 1;

  lf_pkg::state_e      state;
  logic                adc_clk_q;
  logic [ACC_W-1:0]    acc;
  logic [CNT_W-1:0]    cnt;
  logic [2:0]          win_log2;

  logic                strobe_c;
  logic                take_c;
  logic                first_c;
  logic                last_c;
  logic                done_c;
  logic                load_c;
  logic                drop_c;
  logic [ACC_W-1:0]    acc_sum_c;
  logic [CNT_W-1:0]    win_len_c;
  logic [SAMPLE_W-1:0] avg_c;
  logic [SAMPLE_W-1:0] min_c;
  logic [SAMPLE_W-1:0] max_c;

  // Window bookkeeping; the completing sample is folded in before the result is formed.
  always_comb begin
    strobe_c  = adc_clk & ~adc_clk_q;
    take_c    = (state == lf_pkg::ST_ACCUM) & enable & strobe_c;
    first_c   = (cnt == '0);
    acc_sum_c = acc + ACC_W'(adc_d);
    win_len_c = CNT_W'(1) << win_log2;
    last_c    = ((cnt + CNT_W'(1)) == win_len_c);
    done_c    = take_c & last_c;
    avg_c     = SAMPLE_W'(acc_sum_c >> win_log2);
    load_c    = done_c & (~out_valid | out_ready);
    drop_c    = done_c & out_valid & ~out_ready;
  end

  lf_minmax_track #(
    .W(SAMPLE_W)
  ) u_minmax (
    .clk    (pck0),
    .reset  (reset),
    .load   (take_c),
    .first  (first_c),
    .sample (adc_d),
    .min_c  (min_c),
    .max_c  (max_c)
  );

  // FSM and accumulator; a completed window restarts in place so no strobe is lost.
  always_ff @(posedge pck0) begin
    if (reset) begin
      state     <= lf_pkg::ST_IDLE;
      adc_clk_q <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
      win_log2  <= '0;
    end else begin
      adc_clk_q <= adc_clk;
      if (!enable) begin
        state <= lf_pkg::ST_IDLE;
        acc   <= '0;
        cnt   <= '0;
      end else if (state == lf_pkg::ST_IDLE) begin
        state    <= lf_pkg::ST_ACCUM;
        win_log2 <= decim_log2;
        acc      <= '0;
        cnt      <= '0;
      end else if (take_c) begin
        if (last_c) begin
          acc      <= '0;
          cnt      <= '0;
          win_log2 <= decim_log2;
        end else begin
          acc <= acc_sum_c;
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

  // One-deep result buffer; a result arriving while the buffer is held is dropped.
  always_ff @(posedge pck0) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_avg   <= '0;
      out_min   <= '0;
      out_max   <= '0;
      overrun   <= 1'b0;
    end else begin
      if (load_c) begin
        out_valid <= 1'b1;
        out_avg   <= avg_c;
        out_min   <= min_c;
        out_max   <= max_c;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (drop_c) begin
        overrun <= 1'b1;
      end else if (clr_overrun) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lf_adc_decimator.sv
// Directed self-checking bench for lf_adc_decimator.
module tb_lf_adc_decimator;

  logic       pck0;
  logic       reset;
  logic       enable;
  logic       adc_clk;
  logic [7:0] adc_d;
  logic [2:0] decim_log2;
  logic       clr_overrun;
  logic       out_ready;
  logic       out_valid;
  logic [7:0] out_avg;
  logic [7:0] out_min;
  logic [7:0] out_max;
  logic       overrun;

  int n_cmp = 0;
  int n_bad = 0;

  lf_adc_decimator dut (
    .pck0        (pck0),
    .reset       (reset),
    .enable      (enable),
    .adc_clk     (adc_clk),
    .adc_d       (adc_d),
    .decim_log2  (decim_log2),
    .clr_overrun (clr_overrun),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_avg     (out_avg),
    .out_min     (out_min),
    .out_max     (out_max),
    .overrun     (overrun)
  );

  initial pck0 = 1'b0;
  always #5 pck0 = ~pck0;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_res(input string tag, input int avg, input int mn, input int mx);
    chk({tag, " valid"}, int'(out_valid), 1);
    chk({tag, " avg"}, int'(out_avg), avg);
    chk({tag, " min"}, int'(out_min), mn);
    chk({tag, " max"}, int'(out_max), mx);
  endtask

  // One sample at the fastest legal rate: adc_clk high one cycle, low one cycle.
  task automatic strobe(input logic [7:0] s);
    @(negedge pck0);
    adc_clk = 1'b1;
    adc_d   = s;
    @(negedge pck0);
    adc_clk = 1'b0;
  endtask

  task automatic restart(input logic [2:0] d);
    @(negedge pck0);
    enable     = 1'b0;
    decim_log2 = d;
    @(negedge pck0);
    enable = 1'b1;
    @(negedge pck0);
  endtask

  initial begin
    reset       = 1'b1;
    enable      = 1'b0;
    adc_clk     = 1'b0;
    adc_d       = '0;
    decim_log2  = '0;
    clr_overrun = 1'b0;
    out_ready   = 1'b1;
    repeat (2) @(negedge pck0);
    chk("rst valid", int'(out_valid), 0);
    chk("rst avg", int'(out_avg), 0);
    chk("rst min", int'(out_min), 0);
    chk("rst max", int'(out_max), 0);
    chk("rst overrun", int'(overrun), 0);
    reset  = 1'b0;
    enable = 1'b1;
    @(negedge pck0);

    // Pass-through, one result per strobe
    strobe(8'h10); chk_res("pass0", 'h10, 'h10, 'h10);
    strobe(8'hF0); chk_res("pass1", 'hF0, 'hF0, 'hF0);
    strobe(8'h80); chk_res("pass2", 'h80, 'h80, 'h80);

    // Window of 4
    restart(3'd2);
    strobe(8'd10); strobe(8'd20); strobe(8'd30);
    chk("w4 early valid", int'(out_valid), 0);
    strobe(8'd41); chk_res("w4", 25, 10, 41);

    // Window of 128 full-scale samples, no accumulator wrap
    restart(3'd7);
    for (int i = 0; i < 127; i++) strobe(8'hFF);
    chk("w128 early valid", int'(out_valid), 0);
    strobe(8'hFF); chk_res("w128", 'hFF, 'hFF, 'hFF);

    // Overrun: second result dropped while buffer held
    restart(3'd1);
    out_ready = 1'b0;
    strobe(8'd1); strobe(8'd3);
    chk_res("ovr first", 2, 1, 3);
    chk("ovr flag pre", int'(overrun), 0);
    strobe(8'd5); strobe(8'd7);
    chk_res("ovr held", 2, 1, 3);
    chk("ovr flag", int'(overrun), 1);
    @(negedge pck0); clr_overrun = 1'b1;
    @(negedge pck0); clr_overrun = 1'b0;
    chk("ovr cleared", int'(overrun), 0);
    chk_res("ovr still held", 2, 1, 3);
    out_ready = 1'b1;
    @(negedge pck0);
    chk("ovr transferred", int'(out_valid), 0);

    // Drop wins over a simultaneous clear
    out_ready = 1'b0;
    strobe(8'd2); strobe(8'd4);
    chk_res("set-wins first", 3, 2, 4);
    clr_overrun = 1'b1;
    strobe(8'd6); strobe(8'd8);
    clr_overrun = 1'b0;
    chk("set-wins flag", int'(overrun), 1);
    chk("set-wins avg", int'(out_avg), 3);
    out_ready = 1'b1;
    @(negedge pck0); clr_overrun = 1'b1;
    @(negedge pck0); clr_overrun = 1'b0;
    chk("set-wins drained", int'(out_valid), 0);
    chk("set-wins cleared", int'(overrun), 0);

    // Enable dropped mid-window discards the partial window
    restart(3'd2);
    strobe(8'h77); strobe(8'h77);
    @(negedge pck0); enable = 1'b0;
    @(negedge pck0);
    chk("abort valid", int'(out_valid), 0);
    enable = 1'b1;
    @(negedge pck0);
    strobe(8'h40); strobe(8'h40); strobe(8'h40);
    chk("abort early valid", int'(out_valid), 0);
    strobe(8'h40); chk_res("abort redo", 'h40, 'h40, 'h40);
    @(negedge pck0);
    chk("abort single result", int'(out_valid), 0);

    // decim_log2 change mid-window applies at the next boundary
    strobe(8'd4);
    decim_log2 = 3'd1;
    strobe(8'd8);
    chk("chg no early", int'(out_valid), 0);
    strobe(8'd12);
    chk("chg no early2", int'(out_valid), 0);
    strobe(8'd16); chk_res("chg old win", 10, 4, 16);
    strobe(8'd100);
    chk("chg new early", int'(out_valid), 0);
    strobe(8'd50); chk_res("chg new win", 75, 50, 100);

    // Reset mid-window while a result is held
    restart(3'd1);
    out_ready = 1'b0;
    strobe(8'd9); strobe(8'd11);
    chk_res("pre-rst", 10, 9, 11);
    strobe(8'd200);
    @(negedge pck0); reset = 1'b1;
    @(negedge pck0); reset = 1'b0;
    chk("post-rst valid", int'(out_valid), 0);
    chk("post-rst avg", int'(out_avg), 0);
    chk("post-rst min", int'(out_min), 0);
    chk("post-rst max", int'(out_max), 0);
    chk("post-rst overrun", int'(overrun), 0);
    @(negedge pck0);
    out_ready = 1'b1;
    strobe(8'd30);
    chk("post-rst early", int'(out_valid), 0);
    strobe(8'd50); chk_res("post-rst win", 40, 30, 50);

    repeat (2) @(negedge pck0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
